udt_ctrl_pkt_gen: RTL



---
 rtl/udt_pkg.sv | 66 ++++++
 rtl/udt_ts_counter.sv | 28 ++
 rtl/udt_ctrl_pkt_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// Shared UDT control-packet types, codes and sizing.
package udt_pkg;

    localparam int unsigned UDT_TYPE_W     = 4;
    localparam int unsigned UDT_WORD_W     = 32;
    localparam int unsigned UDT_BEAT_W     = 64;
    localparam int unsigned UDT_KEEP_W     = UDT_BEAT_W / 8;
    localparam int unsigned UDT_INFO_WORDS = 12;
    localparam int unsigned UDT_INFO_W     = UDT_INFO_WORDS * UDT_WORD_W;
    localparam int unsigned UDT_BIDX_W     = 3;

    localparam logic [UDT_TYPE_W-1:0] UDT_T_HS   = 4'd0;
    localparam logic [UDT_TYPE_W-1:0] UDT_T_KA   = 4'd1;
    localparam logic [UDT_TYPE_W-1:0] UDT_T_ACK  = 4'd2;
    localparam logic [UDT_TYPE_W-1:0] UDT_T_NAK  = 4'd3;
    localparam logic [UDT_TYPE_W-1:0] UDT_T_SHUT = 4'd5;
    localparam logic [UDT_TYPE_W-1:0] UDT_T_ACK2 = 4'd6;

    localparam logic UDT_CTRL_FLAG = 1'b1;

    // Body beats (two info words per beat) for the types that carry a body
    localparam logic [UDT_BIDX_W-1:0] UDT_BODY_ACK = 3'd3;
    localparam logic [UDT_BIDX_W-1:0] UDT_BODY_HS  = 3'd6;
    localparam logic [UDT_BIDX_W-1:0] UDT_BODY_NAK = 3'd1;

    // Packed index of info word0 (occupies the top 32 bits of cmd_info)
    localparam logic [3:0] UDT_WORD0_IDX = 4'd11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_BODY
    } udt_ctrl_state_t;

    typedef logic [UDT_INFO_WORDS-1:0][UDT_WORD_W-1:0] udt_info_t;

    // Command fields captured at accept
    typedef struct packed {
        logic [UDT_TYPE_W-1:0] ctype;
        logic [UDT_WORD_W-1:0] ts;
        logic [UDT_WORD_W-1:0] sock;
        udt_info_t             info;
    } udt_ctrl_cmd_t;

    typedef struct packed {
        logic [UDT_BEAT_W-1:0] data;
        logic [UDT_KEEP_W-1:0] keep;
    } udt_beat_t;

    function automatic logic udt_type_supported(input logic [UDT_TYPE_W-1:0] t);
        return (t == UDT_T_HS) || (t == UDT_T_KA) || (t == UDT_T_ACK) ||
               (t == UDT_T_NAK) || (t == UDT_T_SHUT) || (t == UDT_T_ACK2);
    endfunction

    function automatic logic [UDT_BIDX_W-1:0] udt_body_beats(input logic [UDT_TYPE_W-1:0] t);
        case (t)
            UDT_T_HS:  return UDT_BODY_HS;
            UDT_T_ACK: return UDT_BODY_ACK;
            UDT_T_NAK: return UDT_BODY_NAK;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/udt_ts_counter.sv
// Free-running microsecond timestamp: prescaler plus 32-bit wrapping counter.
module udt_ts_counter #(
    parameter int unsigned CLK_PER_US = 156
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    output logic [31:0] ts_now
);

    localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);

    logic [PRE_W-1:0] pre;

    // Count clocks within a microsecond; bump the timestamp on the wrap
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            pre    <= '0;
            ts_now <= 32'd0;
        end else if (pre == PRE_MAX) begin
            pre    <= '0;
            ts_now <= ts_now + 32'd1;
        end else begin
            pre    <= pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/udt_ctrl_pkt_gen.sv
// UDT control packet builder: command latch, header/body beat mux, AXI-Stream FSM.
module udt_ctrl_pkt_gen
    import udt_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 156
) (
    input  logic                  core_clk,
    input  logic                  core_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [UDT_TYPE_W-1:0] cmd_type,
    input  logic [UDT_WORD_W-1:0] cmd_addl,
    input  logic [UDT_INFO_W-1:0] cmd_info,
    input  logic [UDT_WORD_W-1:0] dst_sock_id,
    output logic [UDT_BEAT_W-1:0] out_tdata,
    output logic [UDT_KEEP_W-1:0] out_tkeep,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast,
    output logic                  err_unsup,
    output logic [UDT_WORD_W-1:0] ts_now
);

    udt_ctrl_state_t       state;
    udt_ctrl_cmd_t         cmd_q;
    logic [UDT_BIDX_W-1:0] body_n;
    logic [UDT_BIDX_W-1:0] beat_idx;
    logic [UDT_BIDX_W-1:0] nxt_idx_c;
    udt_beat_t             nxt_beat_c;
    logic                  beat_done_c;

    udt_ts_counter #(.CLK_PER_US(CLK_PER_US)) u_ts (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .ts_now     (ts_now)
    );

    // Body beat idx: two info words, or the NAK single/range special case
    function automatic udt_beat_t body_beat(input udt_ctrl_cmd_t c, input logic [UDT_BIDX_W-1:0] idx);
        udt_beat_t  b;
        logic [3:0] wi;
        wi     = 4'(UDT_WORD0_IDX - {idx, 1'b0});
        b.data = {c.info[wi], c.info[4'(wi - 4'd1)]};
        b.keep = 8'hFF;
        if ((c.ctype == UDT_T_NAK) && !c.info[UDT_WORD0_IDX][31]) begin
            b.data = {c.info[UDT_WORD0_IDX], 32'h0};
            b.keep = 8'hF0;
        end
        return b;
    endfunction

    assign cmd_ready   = (state == ST_IDLE);
    assign beat_done_c = out_tvalid && out_tready;

    // Select the body beat to present after the current one
    always_comb begin
        nxt_idx_c  = 3'd0;
        if (state == ST_BODY) begin
            nxt_idx_c = beat_idx + 3'd1;
        end
        nxt_beat_c = body_beat(cmd_q, nxt_idx_c);
    end

    // Packet FSM with registered stream outputs
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state      <= ST_INIT;
            cmd_q      <= '0;
            body_n     <= '0;
            beat_idx   <= '0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            err_unsup  <= 1'b0;
        end else begin
            err_unsup <= 1'b0;
            case (state)
                ST_INIT: state <= ST_IDLE;

                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (udt_type_supported(cmd_type)) begin
                            cmd_q.ctype <= cmd_type;
                            cmd_q.ts    <= ts_now;
                            cmd_q.sock  <= dst_sock_id;
                            cmd_q.info  <= cmd_info;
                            body_n      <= udt_body_beats(cmd_type);
                            out_tdata   <= {UDT_CTRL_FLAG, 15'(cmd_type), 16'h0,
                                            ((cmd_type == UDT_T_ACK) || (cmd_type == UDT_T_ACK2))
                                                ? cmd_addl : 32'h0};
                            out_tkeep   <= 8'hFF;
                            out_tvalid  <= 1'b1;
                            out_tlast   <= 1'b0;
                            state       <= ST_HDR0;
                        end else begin
                            err_unsup   <= 1'b1;
                        end
                    end
                end

                ST_HDR0: begin
                    if (beat_done_c) begin
                        out_tdata <= {cmd_q.ts, cmd_q.sock};
                        out_tlast <= (body_n == 3'd0);
                        state     <= ST_HDR1;
                    end
                end

                ST_HDR1: begin
                    if (beat_done_c) begin
                        if (body_n == 3'd0) begin
                            out_tdata  <= '0;
                            out_tkeep  <= '0;
                            out_tvalid <= 1'b0;
                            out_tlast  <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            beat_idx  <= 3'd0;
                            out_tdata <= nxt_beat_c.data;
                            out_tkeep <= nxt_beat_c.keep;
                            out_tlast <= (body_n == 3'd1);
                            state     <= ST_BODY;
                        end
                    end
                end

                ST_BODY: begin
                    if (beat_done_c) begin
                        if (out_tlast) begin
                            out_tdata  <= '0;
                            out_tkeep  <= '0;
                            out_tvalid <= 1'b0;
                            out_tlast  <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            beat_idx  <= nxt_idx_c;
                            out_tdata <= nxt_beat_c.data;
                            out_tkeep <= nxt_beat_c.keep;
                            out_tlast <= ((beat_idx + 3'd2) == body_n);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
